// File: rtl/arbitro_fifos.sv
// ---------------------------------------------------------------------------
// arbitro_fifos
//
// Round-robin scheduler between four input virtual-channel FIFOs and four
// output FIFOs. Each cycle it pops at most one word from a non-empty input
// FIFO and pushes it, one cycle later, into the output FIFO selected by the
// word's two class bits (the top two bits of the word). It keeps one
// wrapping word counter per destination, readable through a request/valid
// port.
//
// Ports:
//   clk             - system clock, rising edge
//   reset           - asynchronous reset, active low
//   enable          - active status from the state machine; 0 blocks pops
//   empty_in[3:0]   - empty flags of the input FIFOs
//   data_in         - show-ahead head words, FIFO i on [i*DATA_WIDTH +: DATA_WIDTH]
//   almost_full_out - almost-full flags of the output FIFOs (any one pauses)
//   pop[3:0]        - one-hot pop to the input FIFOs (combinational)
//   push_out[3:0]   - one-hot push to the output FIFOs (registered)
//   data_out        - word being pushed (registered)
//   state_arb       - 00 IDLE, 01 ACTIVE, 10 PAUSE (registered)
//   idle_arb        - IDLE with every input FIFO empty (registered)
//   cnt_req/cnt_sel - counter read request and counter index
//   cnt_valid       - read data valid (one cycle after the request)
//   cnt_value       - counter read data
// ---------------------------------------------------------------------------
module arbitro_fifos #(
    parameter int DATA_WIDTH = 6,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [3:0]              empty_in,
    input  logic [4*DATA_WIDTH-1:0] data_in,
    input  logic [3:0]              almost_full_out,
    output logic [3:0]              pop,
    output logic [3:0]              push_out,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic [1:0]              state_arb,
    output logic                    idle_arb,
    input  logic                    cnt_req,
    input  logic [1:0]              cnt_sel,
    output logic                    cnt_valid,
    output logic [CNT_WIDTH-1:0]    cnt_value
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACTIVE = 2'b01,
        ST_PAUSE  = 2'b10
    } arbState_e;

    arbState_e             state_q;
    logic                  idle_q;
    logic [1:0]            ptr_q;
    logic [3:0]            push_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [CNT_WIDTH-1:0]  cnt_q [4];
    logic                  cntValid_q;
    logic [CNT_WIDTH-1:0]  cntValue_q;

    logic                  pause;
    logic                  allEmpty;
    logic                  go;
    logic [DATA_WIDTH-1:0] headArr [4];
    logic                  grantValid;
    logic [1:0]            grantIdx;
    logic [1:0]            scanIdx;
    logic [DATA_WIDTH-1:0] grantWord;
    logic [1:0]            grantClass;

    // Global qualifiers. reset is part of go so that pop is forced low
    // combinationally while reset is held.
    assign pause    = |almost_full_out;
    assign allEmpty = &empty_in;
    assign go       = reset & enable & ~pause & ~allEmpty;

    // Unpack the flattened head-word bus into one word per FIFO.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            headArr[i] = data_in[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Round-robin search starting at ptr_q; the first non-empty FIFO wins.
    // The 2-bit index addition provides the mod-4 wrap.
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = ptr_q;
        scanIdx    = ptr_q;
        for (int k = 0; k < 4; k++) begin
            scanIdx = ptr_q + 2'(k);
            if (go && !grantValid && !empty_in[scanIdx]) begin
                grantValid = 1'b1;
                grantIdx   = scanIdx;
            end
        end
    end

    assign pop        = grantValid ? (4'b0001 << grantIdx) : 4'b0000;
    assign grantWord  = headArr[grantIdx];
    assign grantClass = grantWord[DATA_WIDTH-1 -: 2];

    // Datapath: the granted word is registered toward the output FIFO named
    // by its class bits, and the pointer moves just past the granted FIFO.
    // A word popped on an edge is always pushed by that edge's registers,
    // so a stall or enable drop right afterwards loses nothing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q  <= 2'd0;
            push_q <= 4'b0000;
            data_q <= '0;
        end else if (grantValid) begin
            ptr_q  <= grantIdx + 2'd1;
            push_q <= 4'b0001 << grantClass;
            data_q <= grantWord;
        end else begin
            push_q <= 4'b0000;
        end
    end

    // Per-destination counters plus the read port. The read returns the
    // value from before any increment happening on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
            cntValid_q <= 1'b0;
            cntValue_q <= '0;
        end else begin
            if (grantValid) begin
                cnt_q[grantClass] <= cnt_q[grantClass] + 1'b1;
            end
            cntValid_q <= cnt_req;
            if (cnt_req) begin
                cntValue_q <= cnt_q[cnt_sel];
            end
        end
    end

    // Status FSM. It only reports; the grant logic uses the live inputs,
    // so every state can be reached directly from every other one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            idle_q  <= 1'b0;
        end else if (enable && pause) begin
            state_q <= ST_PAUSE;
            idle_q  <= 1'b0;
        end else if (enable && !allEmpty) begin
            state_q <= ST_ACTIVE;
            idle_q  <= 1'b0;
        end else begin
            state_q <= ST_IDLE;
            idle_q  <= allEmpty;
        end
    end

    assign push_out  = push_q;
    assign data_out  = data_q;
    assign state_arb = state_q;
    assign idle_arb  = idle_q;
    assign cnt_valid = cntValid_q;
    assign cnt_value = cntValue_q;

endmodule

// File: tb/tb_arbitro_fifos.sv
// ---------------------------------------------------------------------------
// tb_arbitro_fifos
//
// Self-checking bench for arbitro_fifos. A behavioural model (integer
// pointer, modulo arithmetic, integer counters) predicts the expected
// outputs; each test task drives its own scenario and compares inline.
// Inputs change 1 ns after a rising edge, pop is sampled 2 ns later and
// registered outputs are sampled 1 ns after the following rising edge.
// ---------------------------------------------------------------------------
module tb_arbitro_fifos;

    localparam int DW = 6;
    localparam int CW = 5;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic [3:0]    empty_in;
    logic [4*DW-1:0] data_in;
    logic [3:0]    almost_full_out;
    logic [3:0]    pop;
    logic [3:0]    push_out;
    logic [DW-1:0] data_out;
    logic [1:0]    state_arb;
    logic          idle_arb;
    logic          cnt_req;
    logic [1:0]    cnt_sel;
    logic          cnt_valid;
    logic [CW-1:0] cnt_value;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int            mPtr;
    logic [3:0]    mPush;
    logic [DW-1:0] mData;
    logic [1:0]    mState;
    logic          mIdle;
    int            mCnt [4];
    logic          mCntValid;
    logic [CW-1:0] mCntValue;

    arbitro_fifos #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk             (clk),
        .reset           (rst_n),
        .enable          (enable),
        .empty_in        (empty_in),
        .data_in         (data_in),
        .almost_full_out (almost_full_out),
        .pop             (pop),
        .push_out        (push_out),
        .data_out        (data_out),
        .state_arb       (state_arb),
        .idle_arb        (idle_arb),
        .cnt_req         (cnt_req),
        .cnt_sel         (cnt_sel),
        .cnt_valid       (cnt_valid),
        .cnt_value       (cnt_value)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic logic [DW-1:0] headOf(input int i);
        return data_in[i*DW +: DW];
    endfunction

    // Index of the FIFO that should be granted now, or -1.
    function automatic int modelGrant();
        int idx;
        if (rst_n !== 1'b1 || enable !== 1'b1 || almost_full_out != 4'b0000 || empty_in == 4'hF)
            return -1;
        for (int k = 0; k < 4; k++) begin
            idx = (mPtr + k) % 4;
            if (empty_in[idx] == 1'b0) return idx;
        end
        return -1;
    endfunction

    function automatic logic [3:0] modelPop();
        int g;
        g = modelGrant();
        if (g < 0) return 4'b0000;
        return 4'b0001 << g;
    endfunction

    task automatic modelReset();
        mPtr      = 0;
        mPush     = 4'b0000;
        mData     = '0;
        mState    = 2'b00;
        mIdle     = 1'b0;
        for (int i = 0; i < 4; i++) mCnt[i] = 0;
        mCntValid = 1'b0;
        mCntValue = '0;
    endtask

    // Expected register values after the coming rising edge.
    task automatic modelEdge();
        int g;
        int cls;
        if (rst_n !== 1'b1) begin
            modelReset();
            return;
        end
        g = modelGrant();
        mCntValid = cnt_req;
        if (cnt_req) mCntValue = CW'(mCnt[cnt_sel]);
        if (g >= 0) begin
            mData = headOf(g);
            cls   = int'(mData) / (1 << (DW - 2));
            mPush = 4'b0001 << cls;
            mCnt[cls] = (mCnt[cls] + 1) % (1 << CW);
            mPtr  = (g + 1) % 4;
        end else begin
            mPush = 4'b0000;
        end
        if (enable && almost_full_out != 4'b0000)  mState = 2'b10;
        else if (enable && empty_in != 4'hF)       mState = 2'b01;
        else                                       mState = 2'b00;
        mIdle = (mState == 2'b00) && (empty_in == 4'hF);
    endtask

    task automatic stepEdge();
        modelEdge();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b1;
        empty_in = 4'b0000;
        almost_full_out = 4'b0000;
        data_in = 24'($urandom);
        cnt_req = 1'b1;
        cnt_sel = 2'd2;
        modelReset();
        #2;
        checks++; if (pop !== 4'b0000) begin errors++; $display("[TB] FAIL reset_pop: got %b expected 0000", pop); end
        stepEdge();
        checks++; if (pop !== 4'b0000) begin errors++; $display("[TB] FAIL reset_pop_edge: got %b expected 0000", pop); end
        checks++; if (push_out !== 4'b0000) begin errors++; $display("[TB] FAIL reset_push: got %b expected 0000", push_out); end
        checks++; if (data_out !== 6'd0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 00", data_out); end
        checks++; if (state_arb !== 2'b00) begin errors++; $display("[TB] FAIL reset_state: got %b expected 00", state_arb); end
        checks++; if (idle_arb !== 1'b0) begin errors++; $display("[TB] FAIL reset_idle: got %b expected 0", idle_arb); end
        checks++; if (cnt_valid !== 1'b0 || cnt_value !== 5'd0) begin errors++; $display("[TB] FAIL reset_cnt: got valid %b value %0d expected 0/0", cnt_valid, cnt_value); end
        cnt_req = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [3:0] expSeq [5];
        logic [3:0] expPop;
        expSeq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        enable = 1'b1;
        empty_in = 4'b0000;
        almost_full_out = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            data_in = 24'($urandom);
            #2;
            expPop = modelPop();
            checks++; if (pop !== expSeq[i] || pop !== expPop) begin errors++; $display("[TB] FAIL rr_pop[%0d]: got %b expected %b", i, pop, expSeq[i]); end
            stepEdge();
            checks++; if (push_out !== mPush || data_out !== mData) begin errors++; $display("[TB] FAIL rr_push[%0d]: got %b/%h expected %b/%h", i, push_out, data_out, mPush, mData); end
        end
    endtask

    task automatic test_routing();
        enable = 1'b1;
        empty_in = 4'b1011;
        almost_full_out = 4'b0000;
        data_in = 24'($urandom);
        data_in[2*DW +: DW] = 6'b110101;
        #2;
        checks++; if (pop !== 4'b0100) begin errors++; $display("[TB] FAIL route_pop: got %b expected 0100", pop); end
        stepEdge();
        checks++; if (push_out !== 4'b1000) begin errors++; $display("[TB] FAIL route_push: got %b expected 1000", push_out); end
        checks++; if (data_out !== 6'b110101) begin errors++; $display("[TB] FAIL route_data: got %b expected 110101", data_out); end
        checks++; if (state_arb !== 2'b01) begin errors++; $display("[TB] FAIL route_state: got %b expected 01", state_arb); end
    endtask

    task automatic test_pause();
        logic [3:0] expPop;
        enable = 1'b1;
        empty_in = 4'b0000;
        almost_full_out = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            data_in = 24'($urandom);
            #2;
            expPop = modelPop();
            checks++; if (pop !== expPop) begin errors++; $display("[TB] FAIL pause_pre_pop[%0d]: got %b expected %b", i, pop, expPop); end
            stepEdge();
        end
        // The last grant before the flag is the in-flight word.
        checks++; if (push_out !== mPush || push_out == 4'b0000 || data_out !== mData) begin errors++; $display("[TB] FAIL pause_inflight: got %b/%h expected %b/%h", push_out, data_out, mPush, mData); end
        almost_full_out = 4'b0010;
        #2;
        checks++; if (pop !== 4'b0000) begin errors++; $display("[TB] FAIL pause_pop: got %b expected 0000", pop); end
        stepEdge();
        checks++; if (push_out !== 4'b0000) begin errors++; $display("[TB] FAIL pause_push: got %b expected 0000", push_out); end
        checks++; if (state_arb !== 2'b10) begin errors++; $display("[TB] FAIL pause_state: got %b expected 10", state_arb); end
        stepEdge();
        checks++; if (push_out !== 4'b0000 || state_arb !== 2'b10) begin errors++; $display("[TB] FAIL pause_hold: got %b/%b expected 0000/10", push_out, state_arb); end
        almost_full_out = 4'b0000;
        #2;
        expPop = 4'b0001 << mPtr;
        checks++; if (pop !== expPop) begin errors++; $display("[TB] FAIL pause_resume_pop: got %b expected %b", pop, expPop); end
        stepEdge();
        checks++; if (push_out !== mPush || data_out !== mData || state_arb !== 2'b01) begin errors++; $display("[TB] FAIL pause_resume_push: got %b/%h/%b expected %b/%h/01", push_out, data_out, state_arb, mPush, mData); end
    endtask

    task automatic test_idle();
        enable = 1'b1;
        empty_in = 4'b1111;
        almost_full_out = 4'b0000;
        #2;
        checks++; if (pop !== 4'b0000) begin errors++; $display("[TB] FAIL idle_pop: got %b expected 0000", pop); end
        stepEdge();
        checks++; if (state_arb !== 2'b00 || idle_arb !== 1'b1) begin errors++; $display("[TB] FAIL idle_flag: got %b/%b expected 00/1", state_arb, idle_arb); end
        enable = 1'b0;
        empty_in = 4'b0101;
        #2;
        checks++; if (pop !== 4'b0000) begin errors++; $display("[TB] FAIL idle_disabled_pop: got %b expected 0000", pop); end
        stepEdge();
        checks++; if (state_arb !== 2'b00 || idle_arb !== 1'b0 || push_out !== 4'b0000) begin errors++; $display("[TB] FAIL idle_disabled: got %b/%b/%b expected 00/0/0000", state_arb, idle_arb, push_out); end
    endtask

    task automatic test_counters();
        logic [3:0] expPop;
        logic [1:0] sels [3];
        sels = '{2'd0, 2'd2, 2'd3};
        rst_n = 1'b0;
        #1;
        modelReset();
        rst_n = 1'b1;
        enable = 1'b1;
        almost_full_out = 4'b0000;
        cnt_req = 1'b0;
        for (int n = 0; n < 33; n++) begin
            empty_in = 4'($urandom_range(0, 14));
            for (int i = 0; i < 4; i++) data_in[i*DW +: DW] = {2'b01, 4'($urandom)};
            #1;
            expPop = modelPop();
            checks++; if (pop !== expPop) begin errors++; $display("[TB] FAIL cnt_pop[%0d]: got %b expected %b", n, pop, expPop); end
            stepEdge();
            checks++; if (push_out !== 4'b0010) begin errors++; $display("[TB] FAIL cnt_push[%0d]: got %b expected 0010", n, push_out); end
        end
        empty_in = 4'b1111;
        cnt_req = 1'b1;
        cnt_sel = 2'd1;
        stepEdge();
        checks++; if (cnt_valid !== 1'b1 || cnt_value !== 5'd1) begin errors++; $display("[TB] FAIL cnt_wrap: got valid %b value %0d expected 1/1", cnt_valid, cnt_value); end
        for (int i = 0; i < 3; i++) begin
            cnt_sel = sels[i];
            stepEdge();
            checks++; if (cnt_valid !== 1'b1 || cnt_value !== 5'd0) begin errors++; $display("[TB] FAIL cnt_other[%0d]: got valid %b value %0d expected 1/0", sels[i], cnt_valid, cnt_value); end
        end
        cnt_req = 1'b0;
        stepEdge();
        checks++; if (cnt_valid !== 1'b0 || cnt_value !== 5'd0) begin errors++; $display("[TB] FAIL cnt_idle: got valid %b value %0d expected 0/0", cnt_valid, cnt_value); end
    endtask

    task automatic test_reset_midstream();
        enable = 1'b1;
        empty_in = 4'b0000;
        almost_full_out = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            data_in = 24'($urandom);
            stepEdge();
        end
        data_in = 24'($urandom);
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checks++; if (pop !== 4'b0000 || push_out !== 4'b0000) begin errors++; $display("[TB] FAIL midrst_popush: got %b/%b expected 0000/0000", pop, push_out); end
        checks++; if (data_out !== 6'd0 || state_arb !== 2'b00) begin errors++; $display("[TB] FAIL midrst_regs: got %h/%b expected 00/00", data_out, state_arb); end
        stepEdge();
        rst_n = 1'b1;
        empty_in = 4'b1111;
        cnt_req = 1'b1;
        cnt_sel = 2'($urandom);
        stepEdge();
        checks++; if (cnt_valid !== 1'b1 || cnt_value !== 5'd0) begin errors++; $display("[TB] FAIL midrst_cnt: got valid %b value %0d expected 1/0", cnt_valid, cnt_value); end
        cnt_req = 1'b0;
    endtask

    task automatic test_random();
        logic [3:0] expPop;
        for (int n = 0; n < 400; n++) begin
            enable = ($urandom_range(0, 9) != 0);
            empty_in = 4'($urandom);
            almost_full_out = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            data_in = 24'($urandom);
            cnt_req = 1'($urandom);
            cnt_sel = 2'($urandom);
            #2;
            expPop = modelPop();
            checks++; if (pop !== expPop) begin errors++; $display("[TB] FAIL rand_pop[%0d]: got %b expected %b", n, pop, expPop); end
            stepEdge();
            checks++; if (push_out !== mPush || data_out !== mData) begin errors++; $display("[TB] FAIL rand_push[%0d]: got %b/%h expected %b/%h", n, push_out, data_out, mPush, mData); end
            checks++; if (state_arb !== mState || idle_arb !== mIdle) begin errors++; $display("[TB] FAIL rand_state[%0d]: got %b/%b expected %b/%b", n, state_arb, idle_arb, mState, mIdle); end
            checks++; if (cnt_valid !== mCntValid || cnt_value !== mCntValue) begin errors++; $display("[TB] FAIL rand_cnt[%0d]: got %b/%0d expected %b/%0d", n, cnt_valid, cnt_value, mCntValid, mCntValue); end
        end
        cnt_req = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        enable = 1'b0;
        empty_in = 4'b1111;
        almost_full_out = 4'b0000;
        data_in = '0;
        cnt_req = 1'b0;
        cnt_sel = 2'd0;
        $display("[TB] starting arbitro_fifos bench");
        test_reset();
        test_round_robin();
        test_routing();
        test_pause();
        test_idle();
        test_counters();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
